// File: rtl/sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// sap_control_sequencer
//   Control sequencer for the 8-bit SAP-style datapath. Steps a one-hot
//   T1..T6 ring counter and decodes (t_state, opcode) into the strobes that
//   the PC, MAR, RAM, IR, A, ALU, B and output registers consume.
//
//   Optional feature macro: SAP_EARLY_RING_RESET_EN
//     defined   : the ring returns to T1 straight after the last state that
//                 carries a strobe for the opcode (LDA 5, OUT/NOP 4 T-states;
//                 ADD/SUB keep 6; HLT still freezes).
//     undefined : fixed 6-state ring for every opcode.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   run             : 1 = advance one T-state per clk
//   step            : single-step request, edge detected, used when run=0
//   opcode [OPC_W]  : opcode from the instruction register
//   t_state [6]     : one-hot ring state, bit0 = T1
//   halted          : set once HLT has executed, cleared only by reset
//   cp, ep          : PC increment / PC to bus (active-high)
//   n_lm, n_ce      : load MAR / RAM to bus (active-low)
//   n_li, n_ei      : load IR / IR operand to bus (active-low)
//   n_la, ea        : load A (active-low) / A to bus (active-high)
//   su, eu          : ALU subtract / ALU to bus (active-high)
//   n_lb, n_lo      : load B / load output register (active-low)
// ---------------------------------------------------------------------------
module sap_control_sequencer #(
    parameter int OPC_W    = 4,
    parameter int T_STATES = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic [OPC_W-1:0] opcode,
    output logic [5:0]       t_state,
    output logic             halted,
    output logic             cp,
    output logic             ep,
    output logic             n_lm,
    output logic             n_ce,
    output logic             n_li,
    output logic             n_ei,
    output logic             n_la,
    output logic             ea,
    output logic             su,
    output logic             eu,
    output logic             n_lb,
    output logic             n_lo
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'(1 << (T_STATES - 1));

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

    logic       step_q;
    logic       advance;
    logic [5:0] t_next;
    logic       is_lda, is_alu, is_sub, is_out, is_hlt;

    assign is_lda = (opcode == OP_LDA);
    assign is_sub = (opcode == OP_SUB);
    assign is_alu = (opcode == OP_ADD) || is_sub;
    assign is_out = (opcode == OP_OUT);
    assign is_hlt = (opcode == OP_HLT);

    // Step edge is taken against the registered history, so holding step
    // high yields exactly one advance.
    assign advance = !halted && (run || (step && !step_q));

    always_comb begin
        t_next = {t_state[4:0], t_state[5]};
`ifdef SAP_EARLY_RING_RESET_EN
        // Cut the instruction short after its last strobe state.
        // Everything that is not LDA/ADD/SUB/HLT ends at T4 (OUT, NOP).
        if ((t_state == T5 && is_lda) ||
            (t_state == T4 && !is_lda && !is_alu && !is_hlt))
            t_next = T1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state <= T1;
            halted  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            step_q <= step;
            if (advance) begin
                t_state <= t_next;
                // HLT leaves T4 into T5 and the ring stays there.
                if (t_state == T4 && is_hlt)
                    halted <= 1'b1;
            end
        end
    end

    // Moore decode of registered state; halted forces everything inactive.
    always_comb begin
        cp   = 1'b0;
        ep   = 1'b0;
        n_lm = 1'b1;
        n_ce = 1'b1;
        n_li = 1'b1;
        n_ei = 1'b1;
        n_la = 1'b1;
        ea   = 1'b0;
        su   = 1'b0;
        eu   = 1'b0;
        n_lb = 1'b1;
        n_lo = 1'b1;
        if (!halted) begin
            case (t_state)
                T1: begin
                    ep   = 1'b1;
                    n_lm = 1'b0;
                end
                T2: cp = 1'b1;
                T3: begin
                    n_ce = 1'b0;
                    n_li = 1'b0;
                end
                T4: begin
                    if (is_lda || is_alu) begin
                        n_ei = 1'b0;
                        n_lm = 1'b0;
                    end else if (is_out) begin
                        ea   = 1'b1;
                        n_lo = 1'b0;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        n_ce = 1'b0;
                        n_la = 1'b0;
                    end else if (is_alu) begin
                        n_ce = 1'b0;
                        n_lb = 1'b0;
                    end
                end
                T6: begin
                    if (is_alu) begin
                        eu   = 1'b1;
                        n_la = 1'b0;
                        su   = is_sub;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sap_control_sequencer
//   Scoreboard bench: before each clock the bench model predicts the next
//   t_state / halted / control word and pushes it; after the edge the
//   observed values are popped against it. Follows SAP_EARLY_RING_RESET_EN.
// ---------------------------------------------------------------------------
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       step;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       halted, cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo;

    sap_control_sequencer #(.OPC_W(4), .T_STATES(6)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .opcode(opcode),
        .t_state(t_state), .halted(halted), .cp(cp), .ep(ep), .n_lm(n_lm),
        .n_ce(n_ce), .n_li(n_li), .n_ei(n_ei), .n_la(n_la), .ea(ea), .su(su),
        .eu(eu), .n_lb(n_lb), .n_lo(n_lo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // {t_state[5:0], halted, word[11:0]}
    logic [18:0] sb_q[$];

    // model state
    int m_t;
    bit m_h;
    bit m_sq;
    int lo_cnt;

    logic [11:0] dut_word;
    assign dut_word = {cp, ep, n_lm, n_ce, n_li, n_ei, n_la, ea, su, eu, n_lb, n_lo};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_word(input int t, input logic [3:0] op, input bit h);
        logic w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_su, w_eu, w_lb, w_lo;
        w_cp = 0; w_ep = 0; w_ea = 0; w_su = 0; w_eu = 0;
        w_lm = 1; w_ce = 1; w_li = 1; w_ei = 1; w_la = 1; w_lb = 1; w_lo = 1;
        if (!h) begin
            case (t)
                0: begin w_ep = 1; w_lm = 0; end
                1: w_cp = 1;
                2: begin w_ce = 0; w_li = 0; end
                3: if (op <= 4'd2) begin w_ei = 0; w_lm = 0; end
                   else if (op == 4'd14) begin w_ea = 1; w_lo = 0; end
                4: if (op == 4'd0) begin w_ce = 0; w_la = 0; end
                   else if (op == 4'd1 || op == 4'd2) begin w_ce = 0; w_lb = 0; end
                5: if (op == 4'd1 || op == 4'd2) begin w_eu = 1; w_la = 0; w_su = (op == 4'd2); end
                default: ;
            endcase
        end
        return {w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_su, w_eu, w_lb, w_lo};
    endfunction

    function automatic logic [18:0] exp_pack();
        logic [5:0] oh;
        oh = 6'b000001 << m_t;
        return {oh, m_h, exp_word(m_t, opcode, m_h)};
    endfunction

    task automatic compare_out(input string tag);
        logic [18:0] e;
        int drv;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_tstate"}, 32'(t_state), 32'(e[18:13]));
        chk({tag, "_halted"}, 32'(halted), 32'(e[12]));
        chk({tag, "_word"}, 32'(dut_word), 32'(e[11:0]));
        drv = int'(ep) + int'(~n_ce) + int'(~n_ei) + int'(ea) + int'(eu);
        chk({tag, "_one_driver"}, 32'(drv <= 1), 32'd1);
    endtask

    // Predict the effect of the coming edge, push it, take the edge, compare.
    task automatic tick(input string tag);
        bit adv;
        adv = !m_h && (run || (step && !m_sq));
        if (adv) begin
            if (m_t == 3 && opcode == 4'd15) begin
                m_h = 1;
                m_t = 4;
            end else begin
`ifdef SAP_EARLY_RING_RESET_EN
                if ((m_t == 4 && opcode == 4'd0) ||
                    (m_t == 3 && opcode > 4'd2 && opcode != 4'd15))
                    m_t = 0;
                else
                    m_t = (m_t + 1) % 6;
`else
                m_t = (m_t + 1) % 6;
`endif
            end
        end
        m_sq = step;
        sb_q.push_back(exp_pack());
        @(posedge clk);
        #1;
        compare_out(tag);
        if (!n_lo) lo_cnt++;
    endtask

    // Asynchronous reset: checked before any further clock edge.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        m_t = 0; m_h = 0; m_sq = 0;
        sb_q.push_back(exp_pack());
        #1;
        compare_out(tag);
        step  = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'd1;
        lo_cnt = 0;
        #2;
        apply_reset("rst0");

        // ADD fetch/execute, two full instructions incl. wrap
        run = 1'b1; opcode = 4'd1;
        repeat (12) tick("add");
        // SUB
        opcode = 4'd2;
        repeat (6) tick("sub");
        // LDA and a NOP opcode
        opcode = 4'd0;
        repeat (6) tick("lda");
        opcode = 4'd5;
        repeat (6) tick("nop");

        // single-step: held step gives one advance, new edge gives another
        apply_reset("rst_step");
        run = 1'b0; opcode = 4'd1;
        step = 1'b1;
        repeat (5) tick("step_hold");
        chk("step_one_adv", 32'(t_state), 32'h02);
        step = 1'b0;
        tick("step_low");
        step = 1'b1;
        tick("step_again");
        chk("step_two_adv", 32'(t_state), 32'h04);
        step = 1'b0;

        // async reset mid-T4, no clock edge needed
        apply_reset("rst_pre_t4");
        run = 1'b1; opcode = 4'd1;
        repeat (3) tick("to_t4");
        chk("at_t4", 32'(t_state), 32'h08);
        #2;
        apply_reset("rst_mid_t4");

        // repeated OUT: n_lo cadence
        apply_reset("rst_out");
        run = 1'b1; opcode = 4'd14; lo_cnt = 0;
        repeat (12) tick("out");
`ifdef SAP_EARLY_RING_RESET_EN
        chk("out_lo_pulses", 32'(lo_cnt), 32'd3);
`else
        chk("out_lo_pulses", 32'(lo_cnt), 32'd2);
`endif

        // HLT: freeze at T5, outputs inactive, run/step ignored
        apply_reset("rst_hlt");
        run = 1'b1; opcode = 4'd15;
        repeat (4) tick("hlt_enter");
        chk("hlt_halted", 32'(halted), 32'd1);
        repeat (20) tick("hlt_run");
        run = 1'b0;
        repeat (3) begin
            step = 1'b1; tick("hlt_step_hi");
            step = 1'b0; tick("hlt_step_lo");
        end
        chk("hlt_frozen", 32'(t_state), 32'h10);
        apply_reset("rst_final");
        chk("final_unhalted", 32'(halted), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Control sequencer for the 8-bit SAP-style datapath.
- Generates the active-low load/enable strobes and active-high enables that the bus registers consume. These are the b_register, input/MAR register and instruction register.
- Steps a 6-state one-hot ring counter (T1..T6) and decodes the opcode supplied by the instruction register.
- Initiator side of the register control interface; the registers are the responders.

Parameters:
- OPC_W, 4, opcode width from instruction register.
- T_STATES, 6, ring length; values other than 6 are unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  1 = free-run, advance one T-state per clk.
- step  input  1  single-step request, used only when run=0.
- opcode  input  OPC_W  current instruction opcode.
- t_state  output  6  one-hot ring state; bit0=T1.
- halted  output  1  1 after HLT is executed.
- cp  output  1  PC increment.
- ep  output  1  PC to bus.
- n_lm  output  1  load MAR (active-low).
- n_ce  output  1  RAM to bus (active-low).
- n_li  output  1  load instruction register (active-low).
- n_ei  output  1  IR operand to bus (active-low).
- n_la  output  1  load A (active-low).
- ea  output  1  A to bus.
- su  output  1  ALU subtract.
- eu  output  1  ALU to bus.
- n_lb  output  1  load B (active-low).
- n_lo  output  1  load output register (active-low).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - t_state=6'b000001, halted=0, step edge-detector history=0.
  - Control outputs take their decoded T1 values: ep=1, n_lm=0, all others inactive.
- Advance condition, when halted=0:
  - run=1: advance every clk.
  - run=0: advance once per 0->1 transition of step. The transition is detected against the registered previous step value, and the advance takes effect on the clk edge that samples step=1 with history=0.
  - Holding step high gives exactly one advance.
- Ring: T1->T2->...->T6->T1; rotate left, wrap T6->T1.
- Control word is a combinational decode of registered t_state and opcode (Moore; no added latency).
- Inactive levels: 0 for active-high signals, 1 for n_* signals.
- Fetch, all opcodes:
  - T1: ep, n_lm=0.
  - T2: cp.
  - T3: n_ce=0, n_li=0.
- Opcodes (opcode only sampled in T4..T6):
  - LDA=0000: T4 n_ei=0,n_lm=0; T5 n_ce=0,n_la=0; T6 none.
  - ADD=0001: T4 n_ei=0,n_lm=0; T5 n_ce=0,n_lb=0; T6 eu=1,n_la=0.
  - SUB=0010: as ADD, plus T6 su=1.
  - OUT=1110: T4 ea=1,n_lo=0; T5,T6 none.
  - HLT=1111: T4 no strobes. halted is set on the next advance edge and the ring freezes at T5.
  - Any other opcode: NOP, no strobes in T4..T6.
- Halted:
  - All control outputs are forced inactive, including T1 decode.
  - run and step are ignored; only rst_n clears halted.
- At most one bus driver (ep, ~n_ce, ~n_ei, ea, eu) is active in any state.
- A reset asserted mid-instruction returns to T1 immediately and asynchronously; no partial strobes are held.
- If opcode changes mid-instruction, the decode follows the new value; the instruction register guarantees stability from T4.

Optional Feature:
- Macro: SAP_EARLY_RING_RESET_EN.
- Defined:
  - When the current state is the last state with any strobe for the opcode, the next advance goes to T1 instead of continuing.
  - Resulting instruction lengths: LDA 5, OUT 4, NOP 4 T-states; ADD/SUB keep 6.
  - HLT still freezes.
- Undefined: fixed 6-state ring for all opcodes.

Test Plan:
- Reset: rst_n=0 asynchronously mid-T4 -> t_state=000001, halted=0, ep=1, n_lm=0 without waiting for clk.
- Fetch: run=1, opcode=0001 -> per T-state:
  - T1: ep/n_lm.
  - T2: cp.
  - T3: n_ce/n_li.
  - T4: n_ei/n_lm.
  - T5: n_ce/n_lb.
  - T6: eu/n_la, su=0.
  - Then back to T1.
- SUB: opcode=0010 -> T6: eu=1, su=1, n_la=0; no other strobe active.
- Single-step: run=0, hold step=1 for 5 clks -> exactly one advance (000001->000010). Step 0->1 again -> 000100.
- HLT: opcode=1111, run=1 -> halted=1 after the T4 edge. t_state stays 010000 for 20 clks, all outputs inactive, and step pulses have no effect.
- Early reset (macro defined): opcode=1110 -> T1,T2,T3,T4 then T1. Repeated OUT gives n_lo=0 every 4th cycle. With the macro undefined, every 6th cycle.
